// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, icache request, one-entry skid
// buffer for decode back-pressure, pending-redirect capture and the IF/ID
// pipeline register.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr_out,
  output logic [31:0] npc_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    BUFFERED = 2'd1,
    HALTED   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_npc_q, skid_npc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] target_pc;
  logic        redir_any;

  // A redirect arriving this cycle wins over one captured earlier.
  assign pc_plus4  = pc_q + 32'd4;
  assign redir_any = redirect | pend_valid_q;
  assign target_pc = redirect ? redirect_pc : pend_pc_q;

  // The fetch address is the PC itself, so it cannot move during a miss.
  assign imemaddr  = pc_q;
  assign instr_out = instr_q;
  assign npc_out   = npc_q;
  assign valid_out = valid_q;

  // Next-state, PC, skid buffer and IF/ID update logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    skid_instr_d = skid_instr_q;
    skid_npc_d   = skid_npc_q;
    instr_d      = instr_q;
    npc_d        = npc_q;
    valid_d      = valid_q;
    imemREN      = (state_q == FETCH);

    // Remember a redirect until the next PC update consumes it.
    if (redirect) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = redirect_pc;
    end

    case (state_q)
      FETCH: begin
        if (ihit) begin
          if (redir_any) begin
            // Word belongs to the wrong path: drop it and steer the PC.
            pc_d         = target_pc;
            pend_valid_d = 1'b0;
          end else begin
            pc_d = pc_plus4;
            if (stall) begin
              skid_instr_d = imemload;
              skid_npc_d   = pc_plus4;
              state_d      = BUFFERED;
            end else begin
              instr_d = imemload;
              npc_d   = pc_plus4;
              valid_d = 1'b1;
            end
          end
        end
      end
      BUFFERED: begin
        if (redir_any) begin
          pc_d         = target_pc;
          pend_valid_d = 1'b0;
          skid_instr_d = 32'd0;
          skid_npc_d   = 32'd0;
          state_d      = FETCH;
        end else if (!stall) begin
          instr_d = skid_instr_q;
          npc_d   = skid_npc_q;
          valid_d = 1'b1;
          state_d = FETCH;
        end
      end
      HALTED: begin
        pend_valid_d = 1'b0;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // Squash the instruction in IF/ID when control flow changes or on flush.
    if (redirect && (state_q != HALTED)) valid_d = 1'b0;
    if (flush) valid_d = 1'b0;

    // Halt overrides everything except reset and is sticky.
    if (halt) begin
      state_d      = HALTED;
      pc_d         = pc_q;
      pend_valid_d = 1'b0;
      skid_instr_d = 32'd0;
      skid_npc_d   = 32'd0;
      valid_d      = 1'b0;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= FETCH;
      pc_q         <= PC_INIT;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'd0;
      skid_instr_q <= 32'd0;
      skid_npc_q   <= 32'd0;
      instr_q      <= 32'd0;
      npc_q        <= 32'd0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_npc_q   <= skid_npc_d;
      instr_q      <= instr_d;
      npc_q        <= npc_d;
      valid_q      <= valid_d;
    end
  end

endmodule
